histogram_pp: RTL and testbench
===============================

# histogram_pp

Parametrised, single-clock successor to the frame histogram block. It builds a BINS-entry histogram of one armed video frame. It uses two internal RAM banks in ping-pong: one bank is captured while the other holds the previous result for the CPU read port, so readout never blocks capture. Counts saturate, back-to-back hits on the same bin are forwarded, and a per-frame total pixel count is reported. It sits on the pixel stream beside the 2D FIR path; the CPU reads results through the register bridge.

## Interface
Parameters:
- PIX_W, 8, pixel width; BINS = 2**PIX_W.
- CNT_W, 32, bin counter width (2..32).

Ports:
- clk  in  1  pixel/system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_pixel  in  PIX_W  pixel value, i.e. the bin index.
- in_valid  in  1  in_pixel valid this cycle.
- end_of_frame  in  1  marks the last pixel of a frame; qualified by in_valid.
- calc_flag  in  1  arm request, level; rising edge detected internally.
- rd_en  in  1  result read strobe.
- rd_addr  in  PIX_W  result bin to read.
- rd_data  out  CNT_W  bin count; valid 1 cycle after rd_en; holds value otherwise.
- frame_pixels  out  32  pixels counted in the last completed frame; saturates at 2^32-1.
- busy  out  1  high in ARMED, CAPTURE, DRAIN, CLEAR.
- out_valid  out  1  one-cycle pulse: new result bank is readable.

## Operation
- States: CLEAR, IDLE, ARMED, CAPTURE, DRAIN.
- CLEAR
  - Writes 0 to every address of the capture bank, at addresses 0..BINS-1, one per cycle, then goes to IDLE.
  - CLEAR is entered after rst and after every bank swap.
- IDLE: a calc_flag rising edge goes to ARMED.
- ARMED: the first valid pixel with end_of_frame=1 goes to CAPTURE. That pixel itself is not counted.
- CAPTURE: every valid pixel increments capture_bank[in_pixel] and the pixel total. The pixel carrying end_of_frame is counted, then the state goes to DRAIN.
- DRAIN
  - Lasts 2 cycles to flush the RMW pipeline.
  - Then the banks swap, frame_pixels updates, out_valid pulses, and the state goes to CLEAR.
- A calc_flag edge seen in ARMED, CAPTURE, DRAIN or CLEAR sets a pending flag.
  - On entering IDLE with the pending flag set, the block goes straight to ARMED and clears the flag.
  - Multiple edges collapse to one.
- Frame gap:
  - If a frame starts while the block is in CLEAR, the armed capture waits for the next frame boundary; no partial frames are counted.
  - Back-to-back frame capture needs at least BINS+4 idle cycles between frames.
- RMW pipeline (internal RAM has 1-cycle read latency):
  - S0: issue read address.
  - S1: data returns; forward if needed; compute count+1, saturating at 2^CNT_W-1.
  - S2: write.
- Forwarding: if the S1 bin equals the bin being written in S2, or the bin written in the previous cycle, the freshest value is used. Runs of identical pixels therefore count exactly.
- Read port:
  - Always reads the result bank.
  - Bank select is sampled in the rd_en cycle, so a read issued in the out_valid cycle returns new data.
  - Result bank contents are undefined until the first out_valid after reset.
- Reset
  - rst mid-operation aborts any capture; no out_valid is produced.
  - The block re-enters CLEAR, and the pending flag and the calc_flag edge register are cleared.

## Timing
- Reset values: rd_data=0, frame_pixels=0, out_valid=0, busy=1 (in CLEAR).
- After rst deasserts, busy falls BINS cycles later.
- Capture start: the first counted pixel is the first valid pixel after the ARMED end_of_frame pixel.
- The end_of_frame pixel accepted at cycle T:
  - Last write at T+2.
  - Swap at the edge ending T+2.
  - out_valid=1 during T+3 only.
  - CLEAR runs T+3..T+3+BINS-1.
  - busy falls at T+3+BINS, unless pending re-arm keeps it high.
- Throughput: 1 pixel per clock, no back-pressure.
- Read latency: 1 clock; reads are never blocked.

## Test plan
- PIX_W=8, CNT_W=32: reset, arm, 3 frames of 16 pixels (frame under test: values 0..15) -> out_valid pulse once at T+3 of the armed frame's eof; bins 0..15 read 1; bin 16 reads 0; frame_pixels=16.
- Frame of 100 consecutive pixels all 0x42 plus 4 pixels 0x43 -> bin 0x42=100, bin 0x43=4, total 104; checks forwarding.
- CNT_W=4: 20 pixels of value 7 -> bin 7 = 15 (saturated); frame_pixels=20.
- Arm, complete frame A, re-arm during DRAIN; frame B starts ≥BINS+4 cycles later -> two out_valid pulses; reads after the second pulse show only B's counts, with no A residue.
- Re-arm, then frame gap < BINS -> next frame skipped; the following frame is captured; exactly one out_valid.
- rst asserted mid-CAPTURE -> no out_valid; busy=1 for BINS cycles; a fresh armed frame gives exact counts.

Source files
------------

// File: rtl/histogram_pp.sv
// Ping-pong frame histogram: one bank captures an armed frame through a
// forwarding read-modify-write pipeline while the other bank serves CPU reads.
module histogram_pp #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  input  logic             end_of_frame,
  input  logic             calc_flag,
  input  logic             rd_en,
  input  logic [PIX_W-1:0] rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic [31:0]      frame_pixels,
  output logic             busy,
  output logic             out_valid
);

  localparam int BINS = 1 << PIX_W;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_calc_d, r_pend;
  logic [PIX_W-1:0] r_clr_addr;
  logic             r_drain_cnt;
  logic             r_cap_sel;
  logic [3:1]       r_vld_pipe;
  logic [31:0]      r_tot;

  logic [CNT_W-1:0] r_mem0 [BINS];
  logic [CNT_W-1:0] r_mem1 [BINS];

  logic [PIX_W-1:0] r_s1_bin, r_s2_bin, r_s3_bin;
  logic [CNT_W-1:0] r_s1_q, r_s2_cnt, r_s3_cnt;

  logic             w_calc_rise, w_eof_px, w_s0_vld, w_swap, w_we;
  logic [PIX_W-1:0] w_waddr;
  logic [CNT_W-1:0] w_wdata, w_s1_base, w_s1_cnt;

  assign w_calc_rise = calc_flag & ~r_calc_d;
  assign w_eof_px    = in_valid & end_of_frame;
  assign w_s0_vld    = (r_state == S_CAPTURE) & in_valid;
  assign w_swap      = (r_state == S_DRAIN) & r_drain_cnt;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR:   if (&r_clr_addr) w_state_nxt = (r_pend | w_calc_rise) ? S_ARMED : S_IDLE;
      S_IDLE:    if (w_calc_rise) w_state_nxt = S_ARMED;
      S_ARMED:   if (w_eof_px) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_eof_px) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (r_drain_cnt) w_state_nxt = S_CLEAR;
      default:   w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_calc_d     <= 1'b0;
      r_pend       <= 1'b0;
      r_clr_addr   <= '0;
      r_drain_cnt  <= 1'b0;
      r_cap_sel    <= 1'b0;
      r_vld_pipe   <= '0;
      r_tot        <= '0;
      frame_pixels <= '0;
      out_valid    <= 1'b0;
    end else begin
      r_calc_d    <= calc_flag;
      out_valid   <= w_swap;
      r_vld_pipe  <= {r_vld_pipe[2:1], w_s0_vld};
      r_drain_cnt <= (r_state == S_DRAIN) & ~r_drain_cnt;
      // Counter wraps to 0 on the last address, ready for the next CLEAR.
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      if (r_state == S_CLEAR && w_state_nxt == S_ARMED) r_pend <= 1'b0;
      else if (w_calc_rise && r_state != S_IDLE)        r_pend <= 1'b1;
      if (r_state == S_ARMED && w_eof_px)  r_tot <= '0;
      else if (w_s0_vld && r_tot != '1)    r_tot <= r_tot + 1'b1;
      if (w_swap) begin
        r_cap_sel    <= ~r_cap_sel;
        frame_pixels <= r_tot;
      end
    end
  end

  // S1 forwarding: the S2 write is newer than the one retired last cycle.
  always_comb begin
    w_s1_base = r_s1_q;
    if (r_vld_pipe[3] && r_s3_bin == r_s1_bin) w_s1_base = r_s3_cnt;
    if (r_vld_pipe[2] && r_s2_bin == r_s1_bin) w_s1_base = r_s2_cnt;
    w_s1_cnt = (&w_s1_base) ? w_s1_base : w_s1_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    r_s1_q   <= r_cap_sel ? r_mem1[in_pixel] : r_mem0[in_pixel];
    r_s1_bin <= in_pixel;
    r_s2_bin <= r_s1_bin;
    r_s2_cnt <= w_s1_cnt;
    r_s3_bin <= r_s2_bin;
    r_s3_cnt <= r_s2_cnt;
  end

  assign w_we    = (r_state == S_CLEAR) | r_vld_pipe[2];
  assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_s2_bin;
  assign w_wdata = (r_state == S_CLEAR) ? '0 : r_s2_cnt;

  always_ff @(posedge clk) begin
    if (w_we && !r_cap_sel) r_mem0[w_waddr] <= w_wdata;
    if (w_we &&  r_cap_sel) r_mem1[w_waddr] <= w_wdata;
  end

  // CPU port always reads the bank not being captured.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= r_cap_sel ? r_mem0[rd_addr] : r_mem1[rd_addr];
  end

endmodule

// File: tb/tb_histogram_pp.sv
// Directed bench: a 32-bit-count and a 4-bit-count instance run in lockstep
// on the same stimulus so saturation is observed on the same frames.
module tb_histogram_pp;

  logic        clk = 1'b0;
  logic        rst, in_valid, end_of_frame, calc_flag, rd_en;
  logic [7:0]  in_pixel, rd_addr;
  logic [31:0] rd_data_m, fp_m, fp_s;
  logic [3:0]  rd_data_s;
  logic        busy_m, busy_s, ov_m, ov_s;

  histogram_pp #(.PIX_W(8), .CNT_W(32)) u_main (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .end_of_frame(end_of_frame), .calc_flag(calc_flag), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data_m), .frame_pixels(fp_m),
    .busy(busy_m), .out_valid(ov_m));

  histogram_pp #(.PIX_W(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .end_of_frame(end_of_frame), .calc_flag(calc_flag), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data_s), .frame_pixels(fp_s),
    .busy(busy_s), .out_valid(ov_s));

  always #5 clk = ~clk;

  int cyc = 0;
  int ov_cnt = 0, ov_cnt_s = 0, ov_cyc = -1;
  int total = 0, bad = 0;
  int eof_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ov_m) begin ov_cnt++; ov_cyc = cyc; end
    if (ov_s) ov_cnt_s++;
  end

  typedef struct {
    int          ph;
    logic [7:0]  addr;
    logic [31:0] em;
    logic [3:0]  es;
  } vec_t;
  vec_t vt[$];

  task automatic add(input int ph, input logic [7:0] a, input logic [31:0] em, input logic [3:0] es);
    vec_t v;
    v.ph = ph; v.addr = a; v.em = em; v.es = es;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_px(input logic [7:0] p, input bit e);
    in_valid = 1'b1; in_pixel = p; end_of_frame = e;
    if (e) eof_cyc = cyc;
    tick();
    in_valid = 1'b0; end_of_frame = 1'b0;
  endtask

  task automatic send_run(input logic [7:0] base, input int step, input int n, input bit eof_last);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = base + 8'(i * step);
      send_px(p, eof_last && (i == n - 1));
    end
  endtask

  task automatic arm;
    calc_flag = 1'b1; tick(); calc_flag = 1'b0; tick();
  endtask

  task automatic do_rd(input logic [7:0] a, output logic [31:0] m, output logic [3:0] s);
    rd_en = 1'b1; rd_addr = a; tick(); rd_en = 1'b0;
    m = rd_data_m; s = rd_data_s;
  endtask

  task automatic wait_idle(input string nm, output int c);
    int k = 0;
    while (busy_m && k < 2000) begin tick(); k++; end
    if (busy_m) chk({nm, "_timeout"}, 1, 0);
    c = cyc;
  endtask

  task automatic run_vecs(input int ph);
    logic [31:0] m;
    logic [3:0]  s;
    foreach (vt[i]) if (vt[i].ph == ph) begin
      do_rd(vt[i].addr, m, s);
      chk($sformatf("p%0d_bin%02h", ph, vt[i].addr), m, vt[i].em);
      chk($sformatf("p%0d_bin%02h_sat", ph, vt[i].addr), s, vt[i].es);
    end
  endtask

  initial begin
    int k, c, base, t_eof;
    logic [31:0] m;
    logic [3:0]  s;

    for (int i = 0; i < 16; i++) add(1, 8'(i), 32'd1, 4'd1);
    add(1, 8'h10, 0, 0); add(1, 8'hF0, 0, 0); add(1, 8'hC8, 0, 0);
    add(2, 8'h42, 100, 15); add(2, 8'h43, 4, 4); add(2, 8'h00, 0, 0);
    add(2, 8'h01, 0, 0); add(2, 8'h05, 0, 0);
    add(3, 8'h07, 20, 15); add(3, 8'h42, 0, 0);
    add(4, 8'h10, 0, 0); add(4, 8'h17, 0, 0); add(4, 8'h20, 1, 1);
    add(4, 8'h27, 1, 1); add(4, 8'h99, 0, 0);
    add(5, 8'h50, 0, 0); add(5, 8'h60, 0, 0); add(5, 8'h70, 1, 1);
    add(5, 8'h73, 1, 1); add(5, 8'h30, 0, 0);
    add(6, 8'h80, 3, 3); add(6, 8'h81, 1, 1);

    rst = 1'b1; in_valid = 0; end_of_frame = 0; calc_flag = 0;
    rd_en = 0; in_pixel = 0; rd_addr = 0;
    idle(3);
    chk("rst_busy", busy_m, 1);
    chk("rst_ov", ov_m, 0);
    chk("rst_rd", rd_data_m, 0);
    chk("rst_fp", fp_m, 0);
    rst = 1'b0;
    k = 0;
    while (busy_m && k < 400) begin tick(); k++; end
    chk("rst_clear_len", k, 256);

    // 3 frames of 16; only the middle one is captured
    base = ov_cnt;
    arm();
    send_run(8'hF0, 1, 16, 1);
    idle(4);
    send_run(8'h00, 1, 16, 1);
    t_eof = eof_cyc;
    idle(2);
    do_rd(8'h05, m, s);
    chk("rd_in_ov_cycle", m, 1);
    chk("rd_in_ov_cycle_sat", s, 1);
    idle(4);
    send_run(8'hC8, 1, 16, 1);
    wait_idle("p1", c);
    chk("p1_ov_count", ov_cnt - base, 1);
    chk("p1_ov_count_sat", ov_cnt_s - base, 1);
    chk("p1_ov_cycle", ov_cyc, t_eof + 3);
    chk("p1_busy_fall", c, t_eof + 3 + 256);
    chk("p1_fp", fp_m, 16);
    run_vecs(1);

    // forwarding: long run of one bin then a short run of the next
    base = ov_cnt;
    arm();
    send_px(8'h01, 1);
    send_run(8'h42, 0, 100, 0);
    send_run(8'h43, 0, 4, 1);
    wait_idle("p2", c);
    chk("p2_ov_count", ov_cnt - base, 1);
    chk("p2_fp", fp_m, 104);
    chk("p2_fp_sat", fp_s, 104);
    run_vecs(2);

    // saturation on the 4-bit instance
    arm();
    send_px(8'h01, 1);
    send_run(8'h07, 0, 20, 1);
    wait_idle("p3", c);
    chk("p3_fp", fp_m, 20);
    chk("p3_fp_sat", fp_s, 20);
    run_vecs(3);

    // re-arm during DRAIN of frame A, frame B after a long gap
    base = ov_cnt;
    arm();
    send_px(8'h01, 1);
    send_run(8'h10, 1, 8, 1);
    calc_flag = 1'b1; tick(); calc_flag = 1'b0;
    idle(270);
    chk("p4_pending_rearm_busy", busy_m, 1);
    send_px(8'h99, 1);
    send_run(8'h20, 1, 8, 1);
    wait_idle("p4", c);
    chk("p4_ov_count", ov_cnt - base, 2);
    chk("p4_fp", fp_m, 8);
    run_vecs(4);

    // re-arm, next frame lands in CLEAR and is skipped
    arm();
    send_px(8'h01, 1);
    send_run(8'h30, 1, 4, 1);
    calc_flag = 1'b1; tick(); calc_flag = 1'b0;
    idle(2);
    base = ov_cnt;
    idle(6);
    send_run(8'h50, 1, 4, 1);
    idle(300);
    send_run(8'h60, 1, 4, 1);
    send_run(8'h70, 1, 4, 1);
    wait_idle("p5", c);
    chk("p5_ov_count", ov_cnt - base, 1);
    chk("p5_fp", fp_m, 4);
    run_vecs(5);

    // reset mid-capture
    arm();
    send_px(8'h01, 1);
    send_run(8'h80, 0, 5, 0);
    base = ov_cnt;
    rst = 1'b1; idle(2); rst = 1'b0;
    k = 0;
    while (busy_m && k < 400) begin tick(); k++; end
    chk("p6_clear_len", k, 256);
    idle(4);
    chk("p6_no_ov", ov_cnt - base, 0);
    chk("p6_fp_reset", fp_m, 0);
    base = ov_cnt;
    arm();
    send_px(8'h01, 1);
    send_run(8'h80, 0, 3, 0);
    send_px(8'h81, 1);
    wait_idle("p6", c);
    chk("p6_ov_count", ov_cnt - base, 1);
    chk("p6_fp", fp_m, 4);
    run_vecs(6);
    chk("sat_idle", busy_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
